l2_sram_bridge: RTL and testbench

// - Slave end of the L2 memory interface: drains the arbiter's request/write-data/read-return streams into one single-port sync SRAM.
// - Sits directly downstream of the L2 arbiter; one request in service at a time, one SRAM access per cycle.

---
 rtl/l2_sram_bridge.sv | 225 ++++++++++++++++++++++
 tb/tb_l2_sram_bridge.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_sram_bridge.sv
// l2_sram_bridge: slave end of the L2 memory interface. Request, write-data and
// read-return streams are serviced one request at a time into a single-port
// synchronous SRAM, with one SRAM access per cycle.
// Optional macro L2_SRAM_READ_PIPE_EN adds an output register on read data
// (read latency 2 instead of 1).
module l2_sram_bridge #(
  parameter int unsigned SRAM_ADDR_W = 14,
  parameter int unsigned L2_ID_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   request_valid,
  output logic                   request_pop,
  input  logic [29:0]            addr,
  input  logic                   rnw,
  input  logic                   is_amo,
  input  logic [4:0]             amo_type_or_burst_size,
  input  logic [L2_ID_W-1:0]     id,
  input  logic                   abort_request,
  input  logic [31:0]            wr_data,
  input  logic [3:0]             wr_data_be,
  input  logic                   wr_data_valid,
  output logic                   wr_data_read,
  output logic [31:0]            rd_data,
  output logic [L2_ID_W-1:0]     rd_id,
  output logic                   rd_data_valid,
  output logic                   sram_en,
  output logic [3:0]             sram_we,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [31:0]            sram_wdata,
  input  logic [31:0]            sram_rdata
);

  localparam logic [4:0] AMO_SC_FN5 = 5'b00011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [4:0]             beat_cnt_q, beat_cnt_d;
  logic [4:0]             last_q, last_d;
  logic [SRAM_ADDR_W-1:0] base_q, base_d;
  logic [L2_ID_W-1:0]     id_q, id_d;
  logic                   sc_abort_q, sc_abort_d;
  logic                   rd_valid_q;
  logic [L2_ID_W-1:0]     rd_id_q;

  logic                   pop_c, wr_read_c, en_c, rd_issue_c;
  logic [3:0]             we_c;
  logic [SRAM_ADDR_W-1:0] addr_c;
  logic [31:0]            wdata_c;
  logic [L2_ID_W-1:0]     issue_id_c;
  logic [4:0]             head_m1_c;
  logic                   head_is_sc_c;
  logic                   unused_addr;

  // Only the low SRAM_ADDR_W word-address bits select an SRAM word.
  assign unused_addr = ^addr[29:SRAM_ADDR_W];

  assign head_m1_c    = is_amo ? 5'd0 : amo_type_or_burst_size;
  assign head_is_sc_c = is_amo && !rnw && (amo_type_or_burst_size == AMO_SC_FN5);

  // Next-state and access decode.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    last_d     = last_q;
    base_d     = base_q;
    id_d       = id_q;
    sc_abort_d = sc_abort_q | abort_request;
    pop_c      = 1'b0;
    wr_read_c  = 1'b0;
    en_c       = 1'b0;
    rd_issue_c = 1'b0;
    we_c       = 4'b0000;
    addr_c     = '0;
    wdata_c    = '0;
    issue_id_c = id_q;

    unique case (state_q)
      ST_IDLE: begin
        if (request_valid) begin
          if (rnw) begin
            pop_c      = 1'b1;
            en_c       = 1'b1;
            rd_issue_c = 1'b1;
            addr_c     = addr[SRAM_ADDR_W-1:0];
            issue_id_c = id;
            base_d     = addr[SRAM_ADDR_W-1:0];
            last_d     = head_m1_c;
            id_d       = id;
            if (head_m1_c != 5'd0) begin
              state_d    = ST_READ;
              beat_cnt_d = 5'd1;
            end
          end else if (head_is_sc_c && (sc_abort_q || abort_request)) begin
            // Failed SC: retire the request without touching the SRAM.
            pop_c      = 1'b1;
            sc_abort_d = 1'b0;
          end else if (wr_data_valid) begin
            pop_c     = 1'b1;
            wr_read_c = 1'b1;
            en_c      = 1'b1;
            we_c      = wr_data_be;
            addr_c    = addr[SRAM_ADDR_W-1:0];
            wdata_c   = wr_data;
            base_d    = addr[SRAM_ADDR_W-1:0];
            last_d    = head_m1_c;
            id_d      = id;
            if (head_m1_c != 5'd0) begin
              state_d    = ST_WRITE;
              beat_cnt_d = 5'd1;
            end
          end
        end
      end

      ST_READ: begin
        en_c       = 1'b1;
        rd_issue_c = 1'b1;
        addr_c     = base_q + SRAM_ADDR_W'(beat_cnt_q);
        if (beat_cnt_q == last_q) begin
          state_d    = ST_IDLE;
          beat_cnt_d = 5'd0;
        end else begin
          beat_cnt_d = beat_cnt_q + 5'd1;
        end
      end

      ST_WRITE: begin
        if (wr_data_valid) begin
          wr_read_c = 1'b1;
          en_c      = 1'b1;
          we_c      = wr_data_be;
          addr_c    = base_q + SRAM_ADDR_W'(beat_cnt_q);
          wdata_c   = wr_data;
          if (beat_cnt_q == last_q) begin
            state_d    = ST_IDLE;
            beat_cnt_d = 5'd0;
          end else begin
            beat_cnt_d = beat_cnt_q + 5'd1;
          end
        end
      end

      default: begin
        state_d    = ST_IDLE;
        beat_cnt_d = 5'd0;
      end
    endcase
  end

  // Request strobes and SRAM port are held quiet while reset is asserted.
  assign request_pop  = pop_c & ~rst;
  assign wr_data_read = wr_read_c & ~rst;
  assign sram_en      = en_c & ~rst;
  assign sram_we      = rst ? 4'b0000 : we_c;
  assign sram_addr    = addr_c;
  assign sram_wdata   = wdata_c;

  // State register and latched request attributes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= 5'd0;
      last_q     <= 5'd0;
      base_q     <= '0;
      id_q       <= '0;
      sc_abort_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      last_q     <= last_d;
      base_q     <= base_d;
      id_q       <= id_d;
      sc_abort_q <= sc_abort_d;
    end
  end

  // Read-return tracking: marks the cycle the SRAM presents data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_id_q    <= '0;
    end else begin
      rd_valid_q <= rd_issue_c;
      if (rd_issue_c) begin
        rd_id_q <= issue_id_c;
      end
    end
  end

`ifdef L2_SRAM_READ_PIPE_EN
  logic                   rd_valid2_q;
  logic [L2_ID_W-1:0]     rd_id2_q;
  logic [31:0]            rd_data2_q;

  // Extra output stage: SRAM data and its id registered once more.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid2_q <= 1'b0;
      rd_id2_q    <= '0;
      rd_data2_q  <= '0;
    end else begin
      rd_valid2_q <= rd_valid_q;
      if (rd_valid_q) begin
        rd_id2_q   <= rd_id_q;
        rd_data2_q <= sram_rdata;
      end
    end
  end

  assign rd_data_valid = rd_valid2_q;
  assign rd_id         = rd_id2_q;
  assign rd_data       = rd_data2_q;
`else
  assign rd_data_valid = rd_valid_q;
  assign rd_id         = rd_id_q;
  assign rd_data       = rd_valid_q ? sram_rdata : 32'h0;
`endif

endmodule

// File: tb/tb_l2_sram_bridge.sv
// Directed bench for l2_sram_bridge with a behavioural sync SRAM model.
module tb_l2_sram_bridge;

`ifdef L2_SRAM_READ_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        request_valid;
  logic        request_pop;
  logic [29:0] addr;
  logic        rnw;
  logic        is_amo;
  logic [4:0]  amo_type_or_burst_size;
  logic [3:0]  id;
  logic        abort_request;
  logic [31:0] wr_data;
  logic [3:0]  wr_data_be;
  logic        wr_data_valid;
  logic        wr_data_read;
  logic [31:0] rd_data;
  logic [3:0]  rd_id;
  logic        rd_data_valid;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [13:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  l2_sram_bridge dut (
    .clk(clk), .rst(rst),
    .request_valid(request_valid), .request_pop(request_pop),
    .addr(addr), .rnw(rnw), .is_amo(is_amo),
    .amo_type_or_burst_size(amo_type_or_burst_size), .id(id),
    .abort_request(abort_request),
    .wr_data(wr_data), .wr_data_be(wr_data_be),
    .wr_data_valid(wr_data_valid), .wr_data_read(wr_data_read),
    .rd_data(rd_data), .rd_id(rd_id), .rd_data_valid(rd_data_valid),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model with a backdoor preload port.
  logic [31:0] mem [0:16383];
  logic        pl_en = 1'b0;
  logic [13:0] pl_addr;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] = pl_data;
    end else if (sram_en) begin
      if (sram_we != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (sram_we[b]) mem[sram_addr][8*b +: 8] = sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Observed activity log.
  logic [31:0] acc_addr [$];
  logic [31:0] acc_we   [$];
  int          acc_cyc  [$];
  logic [31:0] rdq_data [$];
  logic [31:0] rdq_id   [$];
  int          rdq_cyc  [$];
  int          pop_n = 0;
  int          wrr_n = 0;
  int          pop_cyc = -1;

  always @(negedge clk) begin
    if (sram_en) begin
      acc_addr.push_back(32'(sram_addr));
      acc_we.push_back(32'(sram_we));
      acc_cyc.push_back(cyc_n);
    end
    if (request_pop) begin
      pop_n   = pop_n + 1;
      pop_cyc = cyc_n;
    end
    if (wr_data_read) wrr_n = wrr_n + 1;
    if (rd_data_valid) begin
      rdq_data.push_back(rd_data);
      rdq_id.push_back(32'(rd_id));
      rdq_cyc.push_back(cyc_n);
    end
  end

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] qv(input logic [31:0] q[$], input int i);
    return (i >= 0 && i < q.size()) ? q[i] : 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] qc(input int q[$], input int i);
    return (i >= 0 && i < q.size()) ? 32'(q[i]) : 32'hxxxxxxxx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    request_valid = 1'b0; addr = '0; rnw = 1'b0; is_amo = 1'b0;
    amo_type_or_burst_size = '0; id = '0; abort_request = 1'b0;
    wr_data = '0; wr_data_be = 4'hF; wr_data_valid = 1'b0;
  endtask

  task automatic preload(input logic [13:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic req(input logic [29:0] a, input logic r, input logic amo,
                     input logic [4:0] sz, input logic [3:0] i);
    request_valid = 1'b1; addr = a; rnw = r; is_amo = amo;
    amo_type_or_burst_size = sz; id = i;
  endtask

  int a0, r0, p0, w0, c0;

  task automatic snap();
    a0 = acc_addr.size(); r0 = rdq_data.size(); p0 = pop_n; w0 = wrr_n; c0 = cyc_n;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pop", 32'(request_pop), 32'd0);
    chk("rst_en", 32'(sram_en), 32'd0);
    chk("rst_rdv", 32'(rd_data_valid), 32'd0);
    chk("rst_rdata", rd_data, 32'd0);
    chk("rst_rdid", 32'(rd_id), 32'd0);
    tick();

    preload(14'h0010, 32'hDEADBEEF);
    preload(14'h3FFF, 32'h11111111);
    preload(14'h0000, 32'h22222222);
    preload(14'h0040, 32'h11223344);

    // Single read, latency check.
    snap();
    req(30'h10, 1'b1, 1'b0, 5'd0, 4'd3);
    @(negedge clk);
    chk("rd1_pop_same_cycle", 32'(request_pop), 32'd1);
    chk("rd1_we", 32'(sram_we), 32'd0);
    tick();
    idle_inputs();
    repeat (4) tick();
    chk("rd1_acc_n", 32'(acc_addr.size() - a0), 32'd1);
    chk("rd1_acc_addr", qv(acc_addr, a0), 32'h10);
    chk("rd1_ret_n", 32'(rdq_data.size() - r0), 32'd1);
    chk("rd1_data", qv(rdq_data, r0), 32'hDEADBEEF);
    chk("rd1_id", qv(rdq_id, r0), 32'd3);
    chk("rd1_latency", qc(rdq_cyc, r0) - qc(acc_cyc, a0), 32'(LAT));

    // Write burst of 4 with data gaps.
    snap();
    for (int k = 0; k < 7; k++) begin
      if (k == 0) req(30'h20, 1'b0, 1'b0, 5'd3, 4'd1);
      else request_valid = 1'b0;
      wr_data_valid = (k == 0 || k == 2 || k == 3 || k == 5);
      wr_data = 32'hA000_0000 + 32'(k);
      tick();
    end
    idle_inputs();
    tick();
    chk("wb_pop_n", 32'(pop_n - p0), 32'd1);
    chk("wb_acc_n", 32'(acc_addr.size() - a0), 32'd4);
    chk("wb_wrr_n", 32'(wrr_n - w0), 32'd4);
    chk("wb_cyc0", qc(acc_cyc, a0) - 32'(c0), 32'd0);
    chk("wb_cyc1", qc(acc_cyc, a0 + 1) - 32'(c0), 32'd2);
    chk("wb_cyc2", qc(acc_cyc, a0 + 2) - 32'(c0), 32'd3);
    chk("wb_cyc3", qc(acc_cyc, a0 + 3) - 32'(c0), 32'd5);
    chk("wb_addr3", qv(acc_addr, a0 + 3), 32'h23);
    chk("wb_mem20", mem[14'h20], 32'hA000_0000);
    chk("wb_mem21", mem[14'h21], 32'hA000_0002);
    chk("wb_mem22", mem[14'h22], 32'hA000_0003);
    chk("wb_mem23", mem[14'h23], 32'hA000_0005);

    // Read burst of 2 wrapping at the top of the SRAM.
    snap();
    req(30'h3FFF, 1'b1, 1'b0, 5'd1, 4'd5);
    tick();
    idle_inputs();
    repeat (5) tick();
    chk("wrap_acc_n", 32'(acc_addr.size() - a0), 32'd2);
    chk("wrap_addr0", qv(acc_addr, a0), 32'h3FFF);
    chk("wrap_addr1", qv(acc_addr, a0 + 1), 32'h0000);
    chk("wrap_ret_n", 32'(rdq_data.size() - r0), 32'd2);
    chk("wrap_data0", qv(rdq_data, r0), 32'h11111111);
    chk("wrap_data1", qv(rdq_data, r0 + 1), 32'h22222222);
    chk("wrap_id0", qv(rdq_id, r0), 32'd5);
    chk("wrap_id1", qv(rdq_id, r0 + 1), 32'd5);

    // Aborted SC dropped, then a read, then a clean SC that writes.
    snap();
    abort_request = 1'b1;
    tick();
    abort_request = 1'b0;
    req(30'h30, 1'b0, 1'b1, 5'b00011, 4'd2);
    wr_data_valid = 1'b1; wr_data = 32'h0000_00AA;
    tick();
    wr_data_valid = 1'b0;
    req(30'h10, 1'b1, 1'b0, 5'd0, 4'd7);
    tick();
    req(30'h30, 1'b0, 1'b1, 5'b00011, 4'd2);
    wr_data_valid = 1'b1; wr_data = 32'h0000_0055;
    tick();
    idle_inputs();
    repeat (3) tick();
    chk("sc_pop_n", 32'(pop_n - p0), 32'd3);
    chk("sc_acc_n", 32'(acc_addr.size() - a0), 32'd2);
    chk("sc_first_acc_cyc", qc(acc_cyc, a0) - 32'(c0), 32'd2);
    chk("sc_wrr_n", 32'(wrr_n - w0), 32'd1);
    chk("sc_rd_data", qv(rdq_data, r0), 32'hDEADBEEF);
    chk("sc_rd_id", qv(rdq_id, r0), 32'd7);
    chk("sc_mem30", mem[14'h30], 32'h0000_0055);

    // Partial byte-enable write.
    req(30'h40, 1'b0, 1'b0, 5'd0, 4'd0);
    wr_data_valid = 1'b1; wr_data = 32'hAABBCCDD; wr_data_be = 4'b0011;
    @(negedge clk);
    chk("be_we", 32'(sram_we), 32'h3);
    tick();
    idle_inputs();
    tick();
    chk("be_mem40", mem[14'h40], 32'h1122CCDD);

    // Reset in the middle of an 8-beat read.
    req(30'h50, 1'b1, 1'b0, 5'd7, 4'd2);
    tick();
    idle_inputs();
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    snap();
    @(negedge clk);
    chk("mrst_pop", 32'(request_pop), 32'd0);
    chk("mrst_en", 32'(sram_en), 32'd0);
    chk("mrst_we", 32'(sram_we), 32'd0);
    chk("mrst_wrr", 32'(wr_data_read), 32'd0);
    chk("mrst_rdv", 32'(rd_data_valid), 32'd0);
    chk("mrst_rdata", rd_data, 32'd0);
    chk("mrst_rdid", 32'(rd_id), 32'd0);
    repeat (4) tick();
    chk("mrst_no_acc", 32'(acc_addr.size() - a0), 32'd0);
    chk("mrst_no_ret", 32'(rdq_data.size() - r0), 32'd0);

    // Normal service after reset.
    snap();
    req(30'h10, 1'b1, 1'b0, 5'd0, 4'd1);
    tick();
    idle_inputs();
    repeat (4) tick();
    chk("post_pop_cyc", 32'(pop_cyc - c0), 32'd0);
    chk("post_data", qv(rdq_data, r0), 32'hDEADBEEF);
    chk("post_id", qv(rdq_id, r0), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
